blk_368cd9: RTL and testbench
=============================

// Module: ipsxe_floating_point_invsqrt_seg_operand_issue_v1_0
// PURPOSE
//  Issue side of the invsqrt piecewise-polynomial datapath. Takes a normalised mantissa, looks up
//  per-segment coefficients c0 and c1 in a small writable table, and forms |x - a| and its sign.
//  Drives the APM stage that computes c0 +- c1*y, and tracks APM latency so result-valid is aligned.
//  Uses credit-based flow control toward the result consumer, because the APM cannot stall.
// PARAMETERS
//  MAN_WIDTH   52  mantissa width (hidden bit excluded)
//  SEG_BITS    4   segment index bits; table depth = 2**SEG_BITS
//  C0_W        47  c0 width; equals the APM Z/P width
//  C1_W        22  c1 width; equals the APM X width
//  Y_W         17  |x-a| magnitude width; equals the APM Y width
//  APM_LAT     2   cycles from an operand on o_op_* to the APM P output
//  CREDITS     4   consumer result-buffer depth (1..15)
// PORTS
//  i_clk               in   1          clock
//  i_rst_n             in   1          async active-low reset
//  i_valid             in   1          mantissa valid
//  o_ready             out  1          mantissa accepted when i_valid & o_ready
//  i_x_man             in   MAN_WIDTH  mantissa
//  i_cfg_we            in   1          coefficient table write strobe
//  i_cfg_addr          in   SEG_BITS   table entry
//  i_cfg_data          in   C0_W+C1_W  {c0,c1}
//  o_cfg_ready         out  1          table write permitted this cycle
//  o_op_valid          out  1          operand set valid (one-cycle pulse per op)
//  o_a4_plus_a6_z      out  C0_W       c0 operand (APM Z)
//  o_a5                out  C1_W       c1 operand (APM X)
//  o_y                 out  Y_W        |x-a| (APM Y)
//  o_x_minus_a_is_pos  out  1          1: APM adds; 0: APM subtracts (APM MODEY sign)
//  o_res_valid         out  1          APM P output is valid this cycle
//  i_credit_ret        in   1          consumer freed one result slot
//  o_credit_err        out  1          sticky: credit returned while credit count already full
// BEHAVIOUR
//  - Reset values of all outputs: o_op_valid=0, o_res_valid=0, o_credit_err=0, and operand outputs=0.
//    After reset the credit count is CREDITS, so o_ready=1 and o_cfg_ready=1.
//    Table contents are not reset; they are retained across i_rst_n.
//  - Field decode: seg = i_x_man[MAN_WIDTH-1 -: SEG_BITS] and D = i_x_man[MAN_WIDTH-1-SEG_BITS -: Y_W+1].
//    Segment anchor a = 2**Y_W in the D field.
//  - Sign and magnitude from D:
//    pos = D[Y_W]; y = pos ? D-2**Y_W : 2**Y_W-D.
//    D == 0 saturates y to 2**Y_W-1 with pos=0. D == 2**Y_W gives y=0, pos=1.
//  - Pipeline:
//    S1 on accept: synchronous table read at seg, and register y and pos.
//    S2: register the operand outputs and raise o_op_valid.
//    o_op_valid therefore rises exactly 2 cycles after the accept edge.
//    o_res_valid = o_op_valid delayed by APM_LAT through a reset-to-0 shift register, with no bubbles lost.
//  - Back-to-back: with credits available, one accept per cycle, giving one o_op_valid per cycle.
//  - Credits: credit count cnt (0..CREDITS).
//    cnt decrements on accept and increments on i_credit_ret; both in the same cycle leave cnt unchanged.
//    o_ready = (cnt != 0) & ~i_cfg_we.
//    i_credit_ret with cnt == CREDITS and no accept: cnt is held and o_credit_err is set (sticky until reset).
//  - Config: o_cfg_ready = 1 when S1, S2 and the APM_LAT shift register are all empty.
//    A write with o_cfg_ready=1 updates the entry at the next edge.
//    A write with o_cfg_ready=0 is dropped.
//    i_cfg_we has priority over i_valid: o_ready=0 in that cycle.
//    A read of an entry in the cycle after its write returns the new data.
//  - Reset mid-operation: all in-flight ops are discarded, the valids clear immediately (async), and cnt returns to CREDITS.
//  - No combinational path from i_valid to o_ready; o_ready depends on cnt and i_cfg_we only.
// TESTING
//  1. Y_W=17, seg 3 holds {c0=47'h1234, c1=22'h155}, D=2**17+5 accepted at cycle 0
//     -> cycle 2: o_op_valid=1, o_y=5, pos=1, c0/c1 as written; cycle 4 (APM_LAT=2): o_res_valid=1.
//  2. D=2**17-9 -> o_y=9, pos=0. D=0 -> o_y=17'h1FFFF, pos=0. D=2**17 -> o_y=0, pos=1.
//  3. Hold i_valid with no credit returns, CREDITS=4
//     -> exactly 4 accepts, then o_ready=0; one i_credit_ret -> exactly 1 further accept.
//  4. Same-cycle accept and i_credit_ret at cnt=2 -> cnt stays 2.
//     i_credit_ret at cnt=4 with no accept -> o_credit_err=1 and stays 1.
//  5. i_cfg_we while an op is still in the APM delay line -> write dropped and the old data is read back.
//     The same write once the pipe is empty -> new data is read.
//     i_cfg_we and i_valid in the same cycle -> no accept.
//  6. Deassert i_rst_n with 3 ops in flight -> o_op_valid and o_res_valid go 0 asynchronously,
//     no stale pulses after release, o_ready=1 and cnt=4.

Source files
------------

// File: rtl/blk_368cd9.sv
// rtl/blk_368cd9.sv - invsqrt segment operand issue stage with coefficient table and credit flow control
// Purpose: decodes a normalised mantissa into a segment index and an offset from the segment anchor.
//   Looks up {c0,c1} for the segment in a writable table, forms |x-a| and its sign, and presents
//   the operand set to the APM. It also tracks APM latency so that o_res_valid lines up with the
//   APM P output. Credits toward the result consumer gate acceptance, because the APM cannot stall.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_valid / o_ready / i_x_man    mantissa input handshake
//   i_cfg_we / i_cfg_addr /
//   i_cfg_data / o_cfg_ready       coefficient table write port ({c0,c1})
//   o_op_valid, o_a4_plus_a6_z,
//   o_a5, o_y, o_x_minus_a_is_pos  APM operand set (Z=c0, X=c1, Y=|x-a|, add/sub select)
//   o_res_valid                    APM P output valid
//   i_credit_ret, o_credit_err     consumer credit return, sticky over-return flag
module blk_368cd9 #(
  parameter int MAN_WIDTH = 52,
  parameter int SEG_BITS  = 4,
  parameter int C0_W      = 47,
  parameter int C1_W      = 22,
  parameter int Y_W       = 17,
  parameter int APM_LAT   = 2,
  parameter int CREDITS   = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [MAN_WIDTH-1:0]   i_x_man,
  input  logic                   i_cfg_we,
  input  logic [SEG_BITS-1:0]    i_cfg_addr,
  input  logic [C0_W+C1_W-1:0]   i_cfg_data,
  output logic                   o_cfg_ready,
  output logic                   o_op_valid,
  output logic [C0_W-1:0]        o_a4_plus_a6_z,
  output logic [C1_W-1:0]        o_a5,
  output logic [Y_W-1:0]         o_y,
  output logic                   o_x_minus_a_is_pos,
  output logic                   o_res_valid,
  input  logic                   i_credit_ret,
  output logic                   o_credit_err
);

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int DEPTH = 2 ** SEG_BITS;
  localparam int LOW_W = MAN_WIDTH - SEG_BITS - Y_W - 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDITS);

  logic [C0_W+C1_W-1:0] coef_tab [DEPTH];

  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 cfg_wr;
  logic [SEG_BITS-1:0]  seg;
  logic [Y_W:0]         d_fld;
  logic [Y_W-1:0]       y_nxt;
  logic                 pos_nxt;
  logic                 s1_valid;
  logic [Y_W-1:0]       s1_y;
  logic                 s1_pos;
  logic [C0_W+C1_W-1:0] s1_coef;
  logic [APM_LAT-1:0]   lat_sr;
  logic                 unused_low;

  assign seg        = i_x_man[MAN_WIDTH-1 -: SEG_BITS];
  assign d_fld      = i_x_man[MAN_WIDTH-1-SEG_BITS -: Y_W+1];
  assign unused_low = ^i_x_man[LOW_W-1:0];

  // Anchor sits at 2**Y_W in the D field; the top D bit is therefore the sign of x-a.
  // Below the anchor the magnitude is 2**Y_W-D, which modulo 2**Y_W is just -D.
  // D==0 would need Y_W+1 bits, so it saturates to all-ones.
  always_comb begin
    pos_nxt = d_fld[Y_W];
    y_nxt   = d_fld[Y_W-1:0];
    if (d_fld == '0) begin
      y_nxt = '1;
    end else if (!d_fld[Y_W]) begin
      y_nxt = {Y_W{1'b0}} - d_fld[Y_W-1:0];
    end
  end

  // o_ready deliberately ignores i_valid; a config write steals the cycle.
  assign o_ready     = (cnt != '0) & ~i_cfg_we;
  assign accept      = i_valid & o_ready;
  assign o_cfg_ready = ~s1_valid & ~o_op_valid & ~(|lat_sr);
  assign cfg_wr      = i_cfg_we & o_cfg_ready;
  assign o_res_valid = lat_sr[APM_LAT-1];

  // Table contents survive reset, so this array has no reset term.
  always_ff @(posedge i_clk) begin
    if (cfg_wr) begin
      coef_tab[i_cfg_addr] <= i_cfg_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid           <= 1'b0;
      s1_y               <= '0;
      s1_pos             <= 1'b0;
      s1_coef            <= '0;
      o_op_valid         <= 1'b0;
      o_a4_plus_a6_z     <= '0;
      o_a5               <= '0;
      o_y                <= '0;
      o_x_minus_a_is_pos <= 1'b0;
      lat_sr             <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_y    <= y_nxt;
        s1_pos  <= pos_nxt;
        s1_coef <= coef_tab[seg];
      end
      o_op_valid <= s1_valid;
      if (s1_valid) begin
        o_a4_plus_a6_z     <= s1_coef[C0_W+C1_W-1:C1_W];
        o_a5               <= s1_coef[C1_W-1:0];
        o_y                <= s1_y;
        o_x_minus_a_is_pos <= s1_pos;
      end
      // Delay line mirrors the APM pipeline; every op shifts through, so none are lost.
      lat_sr <= (lat_sr << 1) | APM_LAT'(o_op_valid);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt          <= CNT_FULL;
      o_credit_err <= 1'b0;
    end else begin
      if (accept && !i_credit_ret) begin
        cnt <= cnt - CNT_W'(1);
      end else if (!accept && i_credit_ret) begin
        // An over-return is a consumer bug: hold the count and flag it.
        if (cnt == CNT_FULL) begin
          o_credit_err <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_blk_368cd9.sv
// tb/tb_blk_368cd9.sv - self-checking bench for blk_368cd9
module tb_blk_368cd9;
  localparam int MAN_WIDTH = 52;
  localparam int SEG_BITS  = 4;
  localparam int C0_W      = 47;
  localparam int C1_W      = 22;
  localparam int Y_W       = 17;
  localparam int APM_LAT   = 2;
  localparam int CREDITS   = 4;
  localparam int CW        = C0_W + C1_W;
  localparam int ANCHOR    = 1 << Y_W;
  localparam int N         = 1024;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [MAN_WIDTH-1:0] i_x_man = '0;
  logic                 i_cfg_we = 1'b0;
  logic [SEG_BITS-1:0]  i_cfg_addr = '0;
  logic [CW-1:0]        i_cfg_data = '0;
  logic                 o_cfg_ready;
  logic                 o_op_valid;
  logic [C0_W-1:0]      o_a4_plus_a6_z;
  logic [C1_W-1:0]      o_a5;
  logic [Y_W-1:0]       o_y;
  logic                 o_x_minus_a_is_pos;
  logic                 o_res_valid;
  logic                 i_credit_ret = 1'b0;
  logic                 o_credit_err;

  always #5 clk = ~clk;

  blk_368cd9 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_x_man(i_x_man),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .o_cfg_ready(o_cfg_ready),
    .o_op_valid(o_op_valid), .o_a4_plus_a6_z(o_a4_plus_a6_z), .o_a5(o_a5), .o_y(o_y),
    .o_x_minus_a_is_pos(o_x_minus_a_is_pos), .o_res_valid(o_res_valid),
    .i_credit_ret(i_credit_ret), .o_credit_err(o_credit_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: credit count, table image, and per-cycle expected operand schedule.
  int             cyc = 8;
  int             mcnt = CREDITS;
  bit             merr = 1'b0;
  int             last_acc = -100;
  logic [CW-1:0]  mtab [1 << SEG_BITS];
  bit             exp_op [N];
  logic [Y_W-1:0] exp_y [N];
  bit             exp_pos [N];
  logic [CW-1:0]  exp_coef [N];
  bit             m_acc;
  longint         m_man;
  longint         m_d;
  int             m_seg;
  int             m_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt = CREDITS;
      merr = 1'b0;
      last_acc = -100;
      for (int i = 0; i < N; i++) exp_op[i] = 1'b0;
    end else begin
      m_acc = i_valid && (mcnt != 0) && !i_cfg_we;
      if (i_cfg_we && (cyc - last_acc > 2 + APM_LAT)) mtab[i_cfg_addr] = i_cfg_data;
      exp_op[(cyc + 2) % N] = m_acc;
      if (m_acc) begin
        m_man = longint'(i_x_man);
        m_seg = int'(m_man >> (MAN_WIDTH - SEG_BITS));
        m_d   = (m_man >> (MAN_WIDTH - SEG_BITS - Y_W - 1)) % (2 * ANCHOR);
        if (m_d == 0) begin
          m_y = ANCHOR - 1;
          exp_pos[(cyc + 2) % N] = 1'b0;
        end else if (m_d >= ANCHOR) begin
          m_y = int'(m_d) - ANCHOR;
          exp_pos[(cyc + 2) % N] = 1'b1;
        end else begin
          m_y = ANCHOR - int'(m_d);
          exp_pos[(cyc + 2) % N] = 1'b0;
        end
        exp_y[(cyc + 2) % N]    = Y_W'(m_y);
        exp_coef[(cyc + 2) % N] = mtab[m_seg];
        last_acc = cyc;
      end
      if (m_acc && !i_credit_ret) mcnt--;
      else if (!m_acc && i_credit_ret) begin
        if (mcnt == CREDITS) merr = 1'b1;
        else mcnt++;
      end
      cyc++;
    end
  end

  function automatic logic [MAN_WIDTH-1:0] mk_man(input int sg, input int d);
    logic [63:0] r;
    logic [MAN_WIDTH-1:0] m;
    r = {$urandom(), $urandom()};
    m = r[MAN_WIDTH-1:0];
    m[MAN_WIDTH-1 -: SEG_BITS] = sg[SEG_BITS-1:0];
    m[MAN_WIDTH-1-SEG_BITS -: Y_W+1] = d[Y_W:0];
    return m;
  endfunction

  function automatic int rand_d();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return ANCHOR;
      2: return ANCHOR - 1;
      3: return ANCHOR + 1;
      default: return int'($urandom_range(0, 2 * ANCHOR - 1));
    endcase
  endfunction

  function automatic logic [CW-1:0] rand_coef();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[CW-1:0];
  endfunction

  // Returns all credits and lets the pipe drain.
  task automatic settle();
    int guard;
    i_valid = 1'b0;
    i_cfg_we = 1'b0;
    guard = 0;
    while (mcnt != CREDITS && guard < 40) begin
      i_credit_ret = 1'b1;
      @(negedge clk);
      guard++;
    end
    i_credit_ret = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (o_op_valid !== 1'b0) begin failures++; $display("FAIL reset_op_valid got=%0b exp=0", o_op_valid); end
    checks++; if (o_res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", o_res_valid); end
    checks++; if (o_credit_err !== 1'b0) begin failures++; $display("FAIL reset_credit_err got=%0b exp=0", o_credit_err); end
    checks++; if ({o_a4_plus_a6_z, o_a5, o_y, o_x_minus_a_is_pos} !== '0) begin failures++; $display("FAIL reset_operands got=%0h exp=0", {o_a4_plus_a6_z, o_a5, o_y, o_x_minus_a_is_pos}); end
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", o_ready); end
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%0b exp=1", o_cfg_ready); end
  endtask

  task automatic test_basic();
    for (int s = 0; s < (1 << SEG_BITS); s++) begin
      i_cfg_we = 1'b1; i_cfg_addr = SEG_BITS'(s); i_cfg_data = rand_coef();
      @(negedge clk);
    end
    i_cfg_addr = 4'd3; i_cfg_data = {47'h1234, 22'h155};
    @(negedge clk);
    i_cfg_we = 1'b0;
    @(negedge clk);
    i_valid = 1'b1; i_x_man = mk_man(3, ANCHOR + 5);
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%0b exp=1", o_ready); end
    @(negedge clk);
    i_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      checks++; if (o_op_valid !== (k == 2)) begin failures++; $display("FAIL basic_op_valid k=%0d got=%0b", k, o_op_valid); end
      if (k == 2) begin
        checks++; if (o_y !== 17'd5) begin failures++; $display("FAIL basic_y got=%0h exp=5", o_y); end
        checks++; if (o_x_minus_a_is_pos !== 1'b1) begin failures++; $display("FAIL basic_pos got=%0b exp=1", o_x_minus_a_is_pos); end
        checks++; if (o_a4_plus_a6_z !== 47'h1234) begin failures++; $display("FAIL basic_c0 got=%0h exp=1234", o_a4_plus_a6_z); end
        checks++; if (o_a5 !== 22'h155) begin failures++; $display("FAIL basic_c1 got=%0h exp=155", o_a5); end
      end
      checks++; if (o_res_valid !== (k == 4)) begin failures++; $display("FAIL basic_res_valid k=%0d got=%0b", k, o_res_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_boundaries();
    int dv [3];
    logic [Y_W-1:0] ey [3];
    bit ep [3];
    dv = '{ANCHOR - 9, 0, ANCHOR};
    ey = '{17'd9, 17'h1FFFF, 17'd0};
    ep = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_credit_ret = 1'b1; i_x_man = mk_man($urandom_range(0, 15), dv[i]);
      @(negedge clk);
      i_valid = 1'b0; i_credit_ret = 1'b0;
      @(negedge clk);
      checks++; if (o_op_valid !== 1'b1) begin failures++; $display("FAIL bound%0d_op_valid got=%0b exp=1", i, o_op_valid); end
      checks++; if (o_y !== ey[i]) begin failures++; $display("FAIL bound%0d_y got=%0h exp=%0h", i, o_y, ey[i]); end
      checks++; if (o_x_minus_a_is_pos !== ep[i]) begin failures++; $display("FAIL bound%0d_pos got=%0b exp=%0b", i, o_x_minus_a_is_pos, ep[i]); end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int nops;
    settle();
    nops = 0;
    for (int k = 0; k < 18; k++) begin
      i_valid = (k < 10); i_credit_ret = (k < 10);
      i_x_man = mk_man($urandom_range(0, 15), rand_d());
      #1;
      if (k < 10) begin
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready k=%0d got=%0b exp=1", k, o_ready); end
      end
      @(negedge clk);
      if (o_op_valid === 1'b1) nops++;
      checks++;
      if (o_op_valid !== exp_op[cyc % N]) begin failures++; $display("FAIL b2b_op_valid cyc=%0d got=%0b exp=%0b", cyc, o_op_valid, exp_op[cyc % N]); end
      else if (o_op_valid) begin
        checks++; if (o_y !== exp_y[cyc % N]) begin failures++; $display("FAIL b2b_y got=%0h exp=%0h", o_y, exp_y[cyc % N]); end
        checks++; if (o_x_minus_a_is_pos !== exp_pos[cyc % N]) begin failures++; $display("FAIL b2b_pos got=%0b exp=%0b", o_x_minus_a_is_pos, exp_pos[cyc % N]); end
        checks++; if ({o_a4_plus_a6_z, o_a5} !== exp_coef[cyc % N]) begin failures++; $display("FAIL b2b_coef got=%0h exp=%0h", {o_a4_plus_a6_z, o_a5}, exp_coef[cyc % N]); end
      end
      checks++; if (o_res_valid !== exp_op[(cyc - APM_LAT) % N]) begin failures++; $display("FAIL b2b_res_valid cyc=%0d got=%0b", cyc, o_res_valid); end
    end
    checks++; if (nops != 10) begin failures++; $display("FAIL b2b_op_count got=%0d exp=10", nops); end
  endtask

  task automatic test_random();
    settle();
    for (int k = 0; k < 120; k++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_x_man = mk_man($urandom_range(0, 15), rand_d());
      i_cfg_we = ($urandom_range(0, 7) == 0);
      i_cfg_addr = SEG_BITS'($urandom_range(0, 15));
      i_cfg_data = rand_coef();
      i_credit_ret = ($urandom_range(0, 2) == 0) && (mcnt < CREDITS);
      #1;
      checks++; if (o_ready !== ((mcnt != 0) && !i_cfg_we)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b cnt=%0d", cyc, o_ready, mcnt); end
      checks++; if (o_cfg_ready !== (cyc - last_acc > 2 + APM_LAT)) begin failures++; $display("FAIL rnd_cfg_ready cyc=%0d got=%0b", cyc, o_cfg_ready); end
      @(negedge clk);
      checks++;
      if (o_op_valid !== exp_op[cyc % N]) begin failures++; $display("FAIL rnd_op_valid cyc=%0d got=%0b exp=%0b", cyc, o_op_valid, exp_op[cyc % N]); end
      else if (o_op_valid) begin
        checks++; if (o_y !== exp_y[cyc % N]) begin failures++; $display("FAIL rnd_y got=%0h exp=%0h", o_y, exp_y[cyc % N]); end
        checks++; if (o_x_minus_a_is_pos !== exp_pos[cyc % N]) begin failures++; $display("FAIL rnd_pos got=%0b exp=%0b", o_x_minus_a_is_pos, exp_pos[cyc % N]); end
        checks++; if ({o_a4_plus_a6_z, o_a5} !== exp_coef[cyc % N]) begin failures++; $display("FAIL rnd_coef got=%0h exp=%0h", {o_a4_plus_a6_z, o_a5}, exp_coef[cyc % N]); end
      end
      checks++; if (o_res_valid !== exp_op[(cyc - APM_LAT) % N]) begin failures++; $display("FAIL rnd_res_valid cyc=%0d got=%0b", cyc, o_res_valid); end
      checks++; if (o_credit_err !== merr) begin failures++; $display("FAIL rnd_credit_err got=%0b exp=%0b", o_credit_err, merr); end
    end
    i_cfg_we = 1'b0;
  endtask

  task automatic test_credits();
    int n;
    settle();
    n = 0;
    i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_x_man = mk_man($urandom_range(0, 15), rand_d());
      #1; if (o_ready === 1'b1) n++;
      @(negedge clk);
    end
    checks++; if (n != CREDITS) begin failures++; $display("FAIL credits_drain got=%0d exp=%0d", n, CREDITS); end
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL credits_empty_ready got=%0b exp=0", o_ready); end
    i_credit_ret = 1'b1;
    @(negedge clk);
    i_credit_ret = 1'b0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      #1; if (o_ready === 1'b1) n++;
      @(negedge clk);
    end
    checks++; if (n != 1) begin failures++; $display("FAIL credits_one_return got=%0d exp=1", n); end
    i_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    int n;
    settle();
    i_valid = 1'b1;
    repeat (2) @(negedge clk);
    i_credit_ret = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL same_ready got=%0b exp=1", o_ready); end
    @(negedge clk);
    i_credit_ret = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      #1; if (o_ready === 1'b1) n++;
      @(negedge clk);
    end
    checks++; if (n != 2) begin failures++; $display("FAIL same_cycle_cnt got=%0d exp=2", n); end
    settle();
    checks++; if (o_credit_err !== 1'b0) begin failures++; $display("FAIL err_before got=%0b exp=0", o_credit_err); end
    i_credit_ret = 1'b1;
    @(negedge clk);
    i_credit_ret = 1'b0;
    checks++; if (o_credit_err !== 1'b1) begin failures++; $display("FAIL err_set got=%0b exp=1", o_credit_err); end
    repeat (5) @(negedge clk);
    checks++; if (o_credit_err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", o_credit_err); end
    #1;
    checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL err_ready got=%0b exp=1", o_ready); end
  endtask

  task automatic test_cfg();
    logic [CW-1:0] a;
    logic [CW-1:0] b;
    a = rand_coef();
    b = ~a;
    settle();
    i_cfg_we = 1'b1; i_cfg_addr = 4'd5; i_cfg_data = a;
    #1;
    checks++; if (o_cfg_ready !== 1'b1) begin failures++; $display("FAIL cfg_ready_idle got=%0b exp=1", o_cfg_ready); end
    @(negedge clk);
    i_cfg_we = 1'b0;
    i_valid = 1'b1; i_credit_ret = 1'b1; i_x_man = mk_man(5, rand_d());
    @(negedge clk);
    i_valid = 1'b0; i_credit_ret = 1'b0;
    @(negedge clk);
    checks++; if ({o_a4_plus_a6_z, o_a5} !== a) begin failures++; $display("FAIL cfg_first_read got=%0h exp=%0h", {o_a4_plus_a6_z, o_a5}, a); end
    @(negedge clk);
    i_cfg_we = 1'b1; i_cfg_data = b;
    #1;
    checks++; if (o_cfg_ready !== 1'b0) begin failures++; $display("FAIL cfg_ready_busy got=%0b exp=0", o_cfg_ready); end
    @(negedge clk);
    i_cfg_we = 1'b0;
    repeat (4) @(negedge clk);
    i_valid = 1'b1; i_credit_ret = 1'b1; i_x_man = mk_man(5, rand_d());
    @(negedge clk);
    i_valid = 1'b0; i_credit_ret = 1'b0;
    @(negedge clk);
    checks++; if ({o_a4_plus_a6_z, o_a5} !== a) begin failures++; $display("FAIL cfg_dropped got=%0h exp=%0h", {o_a4_plus_a6_z, o_a5}, a); end
    repeat (4) @(negedge clk);
    i_cfg_we = 1'b1; i_cfg_data = b;
    @(negedge clk);
    i_cfg_we = 1'b0;
    i_valid = 1'b1; i_credit_ret = 1'b1; i_x_man = mk_man(5, rand_d());
    @(negedge clk);
    i_valid = 1'b0; i_credit_ret = 1'b0;
    @(negedge clk);
    checks++; if ({o_a4_plus_a6_z, o_a5} !== b) begin failures++; $display("FAIL cfg_new_read got=%0h exp=%0h", {o_a4_plus_a6_z, o_a5}, b); end
    repeat (4) @(negedge clk);
    i_cfg_we = 1'b1; i_valid = 1'b1;
    #1;
    checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL cfg_priority_ready got=%0b exp=0", o_ready); end
    @(negedge clk);
    i_cfg_we = 1'b0; i_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (o_op_valid !== 1'b0) begin failures++; $display("FAIL cfg_priority_op k=%0d got=%0b exp=0", k, o_op_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    settle();
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_x_man = mk_man($urandom_range(0, 15), rand_d());
      @(negedge clk);
    end
    i_valid = 1'b0;
    checks++; if (o_op_valid !== 1'b1) begin failures++; $display("FAIL rstmid_inflight got=%0b exp=1", o_op_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_op_valid !== 1'b0) begin failures++; $display("FAIL rstmid_op_async got=%0b exp=0", o_op_valid); end
    checks++; if (o_res_valid !== 1'b0) begin failures++; $display("FAIL rstmid_res_async got=%0b exp=0", o_res_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if ((o_op_valid | o_res_valid) !== 1'b0) begin failures++; $display("FAIL rstmid_stale k=%0d op=%0b res=%0b", k, o_op_valid, o_res_valid); end
      @(negedge clk);
    end
    checks++; if (o_credit_err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%0b exp=0", o_credit_err); end
    n = 0;
    i_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_x_man = mk_man($urandom_range(0, 15), rand_d());
      #1; if (o_ready === 1'b1) n++;
      @(negedge clk);
    end
    i_valid = 1'b0;
    checks++; if (n != CREDITS) begin failures++; $display("FAIL rstmid_credits got=%0d exp=%0d", n, CREDITS); end
    settle();
    i_valid = 1'b1; i_credit_ret = 1'b1; i_x_man = mk_man($urandom_range(0, 15), rand_d());
    @(negedge clk);
    i_valid = 1'b0; i_credit_ret = 1'b0;
    @(negedge clk);
    checks++; if (o_op_valid !== 1'b1) begin failures++; $display("FAIL rstmid_op_after got=%0b exp=1", o_op_valid); end
    checks++; if ({o_a4_plus_a6_z, o_a5} !== exp_coef[cyc % N]) begin failures++; $display("FAIL rstmid_table_kept got=%0h exp=%0h", {o_a4_plus_a6_z, o_a5}, exp_coef[cyc % N]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_back_to_back();
    test_random();
    test_credits();
    test_same_cycle();
    test_cfg();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
